// File: rtl/minirv_decode_stage.sv
// minirv_decode_stage: registered miniRV decoder behind a valid/ready handshake.
// Define MINIRV_EXT_EN to add the extended ALU/shift/branch/jal op set.
module minirv_decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16,
`ifdef MINIRV_EXT_EN
    localparam int OP_W = 18
`else
    localparam int OP_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [OP_W-1:0]  out_op,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic             out_rd_we,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rd;
    logic            accept;
    logic [OP_W-1:0] op_d;
    logic [XLEN-1:0] imm_d;
    logic            we_d;
    logic            ill_d;
    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [OP_W-1:0] op_q;
    logic [4:0]      rd_q;
    logic [4:0]      rs1_q;
    logic [4:0]      rs2_q;
    logic            we_q;
    logic [XLEN-1:0] imm_q;
    logic            ill_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign opc = in_instr[6:0];
    assign f3  = in_instr[14:12];
    assign f7  = in_instr[31:25];
    assign rd  = in_instr[11:7];

    assign in_ready = !flush && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Classify the instruction into a one-hot op vector.
    always_comb begin
        op_d    = '0;
        op_d[0] = (opc == 7'h33) && (f3 == 3'b000) && (f7 == 7'h00);
        op_d[1] = (opc == 7'h13) && (f3 == 3'b000);
        op_d[2] = (opc == 7'h37);
        op_d[3] = (opc == 7'h03) && (f3 == 3'b010);
        op_d[4] = (opc == 7'h03) && (f3 == 3'b100);
        op_d[5] = (opc == 7'h23) && (f3 == 3'b010);
        op_d[6] = (opc == 7'h23) && (f3 == 3'b000);
        op_d[7] = (opc == 7'h67) && (f3 == 3'b000);
`ifdef MINIRV_EXT_EN
        op_d[8]  = (opc == 7'h33) && (f3 == 3'b000) && (f7 == 7'h20);
        op_d[9]  = (opc == 7'h33) && (f3 == 3'b111) && (f7 == 7'h00);
        op_d[10] = (opc == 7'h33) && (f3 == 3'b110) && (f7 == 7'h00);
        op_d[11] = (opc == 7'h33) && (f3 == 3'b100) && (f7 == 7'h00);
        op_d[12] = (opc == 7'h13) && (f3 == 3'b001) && (f7 == 7'h00);
        op_d[13] = (opc == 7'h13) && (f3 == 3'b101) && (f7 == 7'h00);
        op_d[14] = (opc == 7'h13) && (f3 == 3'b101) && (f7 == 7'h20);
        op_d[15] = (opc == 7'h63) && (f3 == 3'b000);
        op_d[16] = (opc == 7'h63) && (f3 == 3'b001);
        op_d[17] = (opc == 7'h6F);
`endif
    end

    // Pick the immediate format and rd write enable from the decoded op.
    always_comb begin
        imm_d = '0;
        we_d  = 1'b0;
        ill_d = ~|op_d;
        unique case (1'b1)
            op_d[1], op_d[3], op_d[4], op_d[7]:
                imm_d = XLEN'($signed(in_instr[31:20]));
            op_d[5], op_d[6]:
                imm_d = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            op_d[2]:
                imm_d = XLEN'($signed({in_instr[31:12], 12'b0}));
`ifdef MINIRV_EXT_EN
            op_d[12], op_d[13], op_d[14]:
                imm_d = XLEN'(in_instr[24:20]);
            op_d[15], op_d[16]:
                imm_d = XLEN'($signed({in_instr[31], in_instr[7],
                                       in_instr[30:25], in_instr[11:8],
                                       1'b0}));
            op_d[17]:
                imm_d = XLEN'($signed({in_instr[31], in_instr[19:12],
                                       in_instr[20], in_instr[30:21],
                                       1'b0}));
`endif
            default: imm_d = '0;
        endcase
`ifdef MINIRV_EXT_EN
        we_d = (|op_d[4:0] || op_d[7] || |op_d[14:8] || op_d[17])
               && (rd != 5'd0);
`else
        we_d = (|op_d[4:0] || op_d[7]) && (rd != 5'd0);
`endif
    end

    // Saturating illegal counter; a clear wins but still counts this cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = (accept && ill_d) ? CNT_W'(1) : '0;
        end else if (accept && ill_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Output register: load on accept, drop on flush or drain, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            we_q    <= 1'b0;
            imm_q   <= '0;
            ill_q   <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            pc_q    <= in_pc;
            op_q    <= op_d;
            rd_q    <= rd;
            rs1_q   <= in_instr[19:15];
            rs2_q   <= in_instr[24:20];
            we_q    <= we_d;
            imm_q   <= imm_d;
            ill_q   <= ill_d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Illegal counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = pc_q;
    assign out_op      = op_q;
    assign out_rd      = rd_q;
    assign out_rs1     = rs1_q;
    assign out_rs2     = rs2_q;
    assign out_rd_we   = we_q;
    assign out_imm     = imm_q;
    assign out_illegal = ill_q;
    assign illegal_cnt = cnt_q;

endmodule
